// File: rtl/exec_wb_stage_pkg.sv
// Shared opcode and state encodings for the execute/writeback stage.
// Also holds the helper that says which opcodes produce a register write.
package exec_wb_stage_pkg;

    localparam int EXEC_DATA_W = 8;
    localparam int EXEC_ADDR_W = 4;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_LDI = 4'd8,
        OP_CMP = 4'd9,
        OP_MUL = 4'd10
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    function automatic logic op_writes(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                          OP_SHL, OP_SHR, OP_LDI, OP_MUL};
    endfunction

endpackage

// File: rtl/exec_wb_stage_seq_mul.sv
// Start/done shift-add multiplier, W x W -> 2W, one partial product per clock.
// done_o is high during the last step; product_o is valid in that same cycle.
module seq_mul #(
    parameter int W = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] product_o
);
    localparam int CNT_W = $clog2(W);

    logic [2*W-1:0] mcand_q, acc_q, acc_d;
    logic [W-1:0]   mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic           run_q;

    always_comb begin
        acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
        done_o    = run_q && (cnt_q == CNT_W'(W - 1));
        product_o = acc_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{W{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_wb_stage.sv
// Execute/writeback stage: bypassed operand fetch, 1-cycle ALU, iterative MUL,
// and a single registered write port (wa/wd/we) plus Z/C flags toward reg_file.
module exec_wb_stage
    import exec_wb_stage_pkg::*;
#(
    parameter int DATA_W = EXEC_DATA_W,
    parameter int ADDR_W = EXEC_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        op_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [ADDR_W-1:0] src_a_i,
    input  logic [ADDR_W-1:0] src_b_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [ADDR_W-1:0] ra_o,
    output logic [ADDR_W-1:0] rb_o,
    input  logic [DATA_W-1:0] read_a_i,
    input  logic [DATA_W-1:0] read_b_i,
    output logic [ADDR_W-1:0] wa_o,
    output logic [DATA_W-1:0] wd_o,
    output logic              we_o,
    output logic              flag_z_o,
    output logic              flag_c_o,
    output logic              busy_o
);
    state_e              state_q;
    logic                we_q, flag_z_q, flag_c_q;
    logic [ADDR_W-1:0]   wa_q, mul_dst_q;
    logic [DATA_W-1:0]   wd_q;
    logic [DATA_W-1:0]   opnd_a, opnd_b, alu_res_d;
    logic [DATA_W:0]     sum, diff;
    logic                alu_c_d, alu_upd_d, alu_wr_d;
    logic                accept, mul_start, mul_done;
    logic [2*DATA_W-1:0] product;

    assign ra_o       = src_a_i;
    assign rb_o       = src_b_i;
    assign in_ready_o = (state_q == ST_IDLE);
    assign busy_o     = (state_q == ST_MUL);
    assign we_o       = we_q;
    assign wa_o       = wa_q;
    assign wd_o       = wd_q;
    assign flag_z_o   = flag_z_q;
    assign flag_c_o   = flag_c_q;

    assign accept    = in_valid_i && (state_q == ST_IDLE);
    assign mul_start = accept && (op_i == OP_MUL);

    always_comb begin
        // The write in flight has not reached reg_file yet, so forward it.
        opnd_a = (we_q && (wa_q == src_a_i)) ? wd_q : read_a_i;
        opnd_b = (we_q && (wa_q == src_b_i)) ? wd_q : read_b_i;
        sum    = {1'b0, opnd_a} + {1'b0, opnd_b};
        diff   = {1'b0, opnd_a} - {1'b0, opnd_b};

        alu_res_d = '0;
        alu_c_d   = 1'b0;
        alu_upd_d = 1'b1;
        case (op_i)
            OP_ADD: begin
                alu_res_d = sum[DATA_W-1:0];
                alu_c_d   = sum[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                alu_res_d = diff[DATA_W-1:0];
                alu_c_d   = diff[DATA_W];
            end
            OP_AND: alu_res_d = opnd_a & opnd_b;
            OP_OR:  alu_res_d = opnd_a | opnd_b;
            OP_XOR: alu_res_d = opnd_a ^ opnd_b;
            OP_SHL: begin
                alu_res_d = {opnd_a[DATA_W-2:0], 1'b0};
                alu_c_d   = opnd_a[DATA_W-1];
            end
            OP_SHR: begin
                alu_res_d = {1'b0, opnd_a[DATA_W-1:1]};
                alu_c_d   = opnd_a[0];
            end
            OP_LDI: alu_res_d = imm_i;
            default: alu_upd_d = 1'b0;
        endcase
        alu_wr_d = alu_upd_d && op_writes(op_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            mul_dst_q <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mul_start) begin
                        state_q   <= ST_MUL;
                        mul_dst_q <= dst_i;
                    end else if (accept && alu_upd_d) begin
                        flag_z_q <= (alu_res_d == '0);
                        flag_c_q <= alu_c_d;
                        if (alu_wr_d) begin
                            we_q <= 1'b1;
                            wa_q <= dst_i;
                            wd_q <= alu_res_d;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state_q  <= ST_IDLE;
                        we_q     <= 1'b1;
                        wa_q     <= mul_dst_q;
                        wd_q     <= product[DATA_W-1:0];
                        flag_z_q <= (product[DATA_W-1:0] == '0);
                        flag_c_q <= |product[2*DATA_W-1:DATA_W];
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    seq_mul #(.W(DATA_W)) u_mul (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .start_i   (mul_start),
        .a_i       (opnd_a),
        .b_i       (opnd_b),
        .done_o    (mul_done),
        .product_o (product)
    );

endmodule

// File: tb/tb_exec_wb_stage.sv
// Bench for exec_wb_stage with a behavioural register file and an
// instruction-level reference model compared against the DUT every cycle.
module tb_exec_wb_stage;

    localparam int L_ADD = 1, L_SUB = 2, L_AND = 3, L_OR = 4, L_XOR = 5;
    localparam int L_SHL = 6, L_SHR = 7, L_LDI = 8, L_CMP = 9, L_MUL = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] op = '0, dst = '0, src_a = '0, src_b = '0;
    logic [7:0] imm = '0;
    logic       in_ready, we, flag_z, flag_c, busy;
    logic [3:0] ra, rb, wa;
    logic [7:0] wd, read_a, read_b;

    logic [7:0] rf [16];
    logic [7:0] init_val [16];
    logic [7:0] mrf [16];
    logic [7:0] snap [16];
    logic       lw_c [16];
    logic       rf_load = 1'b1;
    logic       chk_en = 1'b0;
    int         errors = 0;
    int         checks = 0;
    int         w, last_d, o, d, sa, sb, im;
    logic [7:0] snap11;

    // Reference model state: expected outputs after the latest clock edge.
    logic       ewe = 1'b0, ez = 1'b0, ec = 1'b0, mready = 1'b1, mpend = 1'b0, mcar = 1'b0;
    logic [3:0] ewa = '0, mdst = '0;
    logic [7:0] ewd = '0, mres = '0;
    int         mleft = 0;

    always #5 clk = ~clk;

    exec_wb_stage dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .op_i       (op),
        .dst_i      (dst),
        .src_a_i    (src_a),
        .src_b_i    (src_b),
        .imm_i      (imm),
        .ra_o       (ra),
        .rb_o       (rb),
        .read_a_i   (read_a),
        .read_b_i   (read_b),
        .wa_o       (wa),
        .wd_o       (wd),
        .we_o       (we),
        .flag_z_o   (flag_z),
        .flag_c_o   (flag_c),
        .busy_o     (busy)
    );

    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 16; i++) rf[i] <= init_val[i];
        end else if (we) begin
            rf[wa] <= wd;
        end
    end
    assign read_a = rf[ra];
    assign read_b = rf[rb];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  a, b, s, r;
        logic c, wr, fl;
        if (!rst_n) begin
            ewe = 1'b0; ewa = '0; ewd = '0; ez = 1'b0; ec = 1'b0;
            mready = 1'b1; mpend = 1'b0; mleft = 0;
            if (rf_load) for (int i = 0; i < 16; i++) mrf[i] = init_val[i];
            return;
        end
        ewe = 1'b0;
        if (mpend) begin
            mleft--;
            if (mleft == 0) begin
                mpend = 1'b0; mready = 1'b1;
                ewe = 1'b1; ewa = mdst; ewd = mres;
                ez = (mres == 8'h00); ec = mcar;
                mrf[mdst] = mres;
            end
        end else if (mready && in_valid) begin
            a = int'(mrf[src_a]); b = int'(mrf[src_b]);
            r = 0; s = 0; c = 1'b0; wr = 1'b1; fl = 1'b1;
            case (int'(op))
                L_ADD: begin s = a + b; r = s % 256; c = (s > 255); end
                L_SUB: begin r = (a - b + 256) % 256; c = (a < b); end
                L_AND: r = a & b;
                L_OR:  r = a | b;
                L_XOR: r = a ^ b;
                L_SHL: begin r = (a * 2) % 256; c = (a >= 128); end
                L_SHR: begin r = a / 2; c = (a % 2 == 1); end
                L_LDI: r = int'(imm);
                L_CMP: begin r = (a - b + 256) % 256; c = (a < b); wr = 1'b0; end
                L_MUL: begin
                    s = a * b;
                    mpend = 1'b1; mready = 1'b0; mleft = 8; mdst = dst;
                    mres = 8'(s % 256); mcar = (s > 255);
                    wr = 1'b0; fl = 1'b0;
                end
                default: begin wr = 1'b0; fl = 1'b0; end
            endcase
            if (fl) begin ez = (r == 0); ec = c; end
            if (wr) begin
                ewe = 1'b1; ewa = dst; ewd = 8'(r);
                mrf[dst] = 8'(r);
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("we", we, ewe);
            chk("wa", wa, ewa);
            chk("wd", wd, ewd);
            chk("flag_z", flag_z, ez);
            chk("flag_c", flag_c, ec);
            chk("in_ready", in_ready, mready);
            chk("busy", busy, mpend);
            chk("ra", ra, src_a);
            chk("rb", rb, src_b);
            if (we === 1'b1) lw_c[wa] = flag_c;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input int o_, input int d_, input int a_, input int b_, input int i_,
                        output int waits);
        logic r, done;
        waits = 0; done = 1'b0;
        in_valid = 1'b1; op = 4'(o_); dst = 4'(d_); src_a = 4'(a_); src_b = 4'(b_); imm = 8'(i_);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #2;
            if (r === 1'b1) begin
                done = 1'b1;
                break;
            end
            waits++;
        end
        chk("handshake_accept", done, 1'b1);
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            init_val[i] = 8'($urandom_range(0, 255));
            lw_c[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1; rf_load = 1'b0; chk_en = 1'b1;
        chk("rst_we", we, 1'b0);
        chk("rst_wd", wd, 8'h00);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);

        // Reset in the middle of a multiply aborts it with no write
        send(L_LDI, 2, 0, 0, 8'h03, w);
        send(L_LDI, 1, 0, 0, 8'h00, w);
        send(L_MUL, 6, 1, 2, 0, w);
        for (int i = 0; i < 16; i++) snap[i] = rf[i];
        chk("t1_z_pre", flag_z, 1'b1);
        idle(3);
        chk("t1_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        idle(2);
        chk("t1_we", we, 1'b0);
        chk("t1_z", flag_z, 1'b0);
        chk("t1_c", flag_c, 1'b0);
        chk("t1_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        idle(12);
        for (int i = 0; i < 16; i++) chk($sformatf("t1_reg%0d", i), rf[i], snap[i]);

        // Back-to-back dependent ops through the bypass
        send(L_LDI, 1, 0, 0, 8'h0F, w);
        send(L_LDI, 2, 0, 0, 8'hF1, w);
        send(L_ADD, 3, 1, 2, 0, w);
        idle(2);
        chk("t2_r3", rf[3], 8'h00);
        chk("t2_model_r3", mrf[3], 8'h00);
        chk("t2_z", flag_z, 1'b1);
        chk("t2_c", flag_c, 1'b1);

        send(L_SUB, 4, 1, 2, 0, w);
        idle(2);
        chk("t3_r4", rf[4], 8'h1E);
        chk("t3_model_r4", mrf[4], 8'h1E);
        chk("t3_z", flag_z, 1'b0);
        chk("t3_c", flag_c, 1'b1);
        send(L_CMP, 1, 1, 1, 0, w);
        idle(2);
        chk("t3_cmp_z", flag_z, 1'b1);
        chk("t3_cmp_c", flag_c, 1'b0);
        chk("t3_cmp_r1", rf[1], 8'h0F);

        // Multiply, with the next op held valid while busy
        send(L_MUL, 5, 1, 2, 0, w);
        send(L_LDI, 7, 0, 0, 8'h55, w);
        chk("t4_ready_low_cycles", w, 8);
        idle(2);
        chk("t4_r5", rf[5], 8'h1F);
        chk("t4_model_r5", mrf[5], 8'h1F);
        chk("t4_c", lw_c[5], 1'b1);
        chk("t4_r7", rf[7], 8'h55);

        send(L_LDI, 8, 0, 0, 8'h81, w);
        send(L_SHL, 9, 8, 0, 0, w);
        send(L_SHR, 10, 8, 0, 0, w);
        idle(2);
        chk("t5_shl", rf[9], 8'h02);
        chk("t5_shl_c", lw_c[9], 1'b1);
        chk("t5_shr", rf[10], 8'h40);
        chk("t5_shr_c", lw_c[10], 1'b1);
        snap11 = rf[11];
        send(15, 11, 8, 8, 8'hAA, w);
        idle(2);
        chk("t5_undef_r11", rf[11], snap11);
        chk("t5_undef_z", flag_z, 1'b0);
        chk("t5_undef_c", flag_c, 1'b1);

        // Random stream, biased toward reading the previous destination
        last_d = 0;
        for (int n = 0; n < 200; n++) begin
            o  = int'($urandom_range(0, 15));
            d  = int'($urandom_range(0, 15));
            sa = ($urandom_range(0, 2) == 0) ? last_d : int'($urandom_range(0, 15));
            sb = ($urandom_range(0, 2) == 0) ? last_d : int'($urandom_range(0, 15));
            im = int'($urandom_range(0, 255));
            send(o, d, sa, sb, im, w);
            last_d = d;
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(12);
        for (int i = 0; i < 16; i++) chk($sformatf("final_r%0d", i), rf[i], mrf[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
